fifo_umbral: RTL and testbench
==============================

# fifo_umbral

Synchronous FIFO with programmable almost-full/almost-empty thresholds, sitting directly upstream of the control FSM. Each lane instance (Mfs, Vcs, D) buffers data words, exposes occupancy flags, and produces the `empty` and `error` indications the FSM aggregates into its empties and error inputs. Thresholds arrive from the FSM's threshold outputs and are applied live.

## Interface
- `DATA_W`, 6, data word width
- `ADDR_W`, 3, address width; depth = 2^ADDR_W = 8
- `clk`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `push`  in  1  write request
- `data_in`  in  DATA_W  write data
- `pop`  in  1  read request
- `umbral_alto`  in  ADDR_W  almost-full threshold; 0 = disabled
- `umbral_bajo`  in  ADDR_W  almost-empty threshold
- `data_out`  out  DATA_W  registered read data
- `valid_out`  out  1  `data_out` valid this cycle
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `almost_full`  out  1  `umbral_alto != 0 && count >= umbral_alto`
- `almost_empty`  out  1  `count <= umbral_bajo`
- `error`  out  1  overflow/underflow indication
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH

## Operation
- State: write pointer, read pointer (ADDR_W bits each, natural wrap at DEPTH), and a count register (ADDR_W+1 bits).
- Write accepted when `push && (!full || pop)`; `data_in` is stored at the write pointer, and the write pointer increments.
- Read accepted when `pop && !empty`; the word at the read pointer is loaded into `data_out`, `valid_out`=1 next cycle, and the read pointer increments.
- Both accepted in the same cycle: count unchanged. Push+pop at full: both proceed. Push+pop at empty: the write proceeds, the pop is an underflow, and count becomes 1.
- Overflow: `push && full && !pop`. Data is dropped, pointers and count are unchanged, and `error` is raised.
- Underflow: `pop && empty`. Nothing is read, `valid_out`=0, and `error` is raised.
- `data_out` holds its last value when no read is accepted. `valid_out` is 0 on cycles after a non-accepted pop.
- Flags are combinational from `count` and the live thresholds. A threshold change is reflected in the same cycle.
- `umbral_bajo` ≥ count always asserts `almost_empty`. Thresholds are not range-checked.

## Timing
- Reset (async assert, sync-released by the system) clears: pointers=0, count=0, `data_out`=0, `valid_out`=0, `error`=0. Resulting flags: `empty`=1, `full`=0, `almost_full`=0, `almost_empty`=1.
- Reset mid-operation discards all contents immediately. Memory contents are not cleared and are unobservable.
- Write-to-empty-deassert latency: 1 cycle (count updates on the edge that accepts the write).
- Pop-to-data latency: 1 cycle (`data_out`/`valid_out` registered).
- A word written on edge N is readable by a pop presented in cycle N+1 (no fall-through).
- `error` without the macro: a 1-cycle pulse, registered, asserted the cycle after the offending request.

## Configuration
- `FIFO_STICKY_ERROR_EN` defined: `error` is sticky. Once set, it stays 1 until `reset`, and further operations continue normally.
- `FIFO_STICKY_ERROR_EN` undefined: `error` is the 1-cycle pulse described under Timing.

## Structure
- Shared package `fifo_pkg`: `DATA_W`/`ADDR_W` defaults and the derived `DEPTH` constant.
- Same package: localparams for the three lane instances (Mfs, Vcs, D) so the FSM and the FIFOs agree on threshold width.
- One sub-module: `fifo_mem`, a DEPTH×DATA_W register file with one synchronous write port and one synchronous read port. The pointer/count/flag/error logic stays in `fifo_umbral`.

## Test plan
- Reset then idle → `empty`=1, `almost_empty`=1 (umbral_bajo=1), `full`=0, `count`=0, `error`=0, `valid_out`=0.
- 8 pushes of 0x01..0x08 with umbral_alto=6 → `almost_full` rises when count=6, `full`=1 at count=8. Then 8 pops → `data_out` 0x01..0x08 in order, one cycle after each pop, and `empty`=1 at the end.
- FIFO full, push 0x3F without pop → `error` pulse 1 cycle later, count stays 8, and subsequent reads never return 0x3F. With `FIFO_STICKY_ERROR_EN`, `error` stays 1.
- Empty FIFO, pop → `error`=1 next cycle, `valid_out`=0, count stays 0. Push+pop together on empty → count=1 and no `valid_out`.
- FIFO full, push 0x2A and pop together → no error, count stays 8, oldest word output, and 0x2A emerges 8 reads later (pointer wrap verified).
- Count=4 with reset asserted asynchronously between edges → `count`=0 and `empty`=1 immediately. After reset release, a pop → `error`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the umbral FIFOs and the per-lane (Mfs, Vcs, D) instances,
// so the control FSM and the FIFOs agree on data and threshold widths.
package fifo_pkg;

   localparam int FIFO_DATA_W = 6;
   localparam int FIFO_ADDR_W = 3;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   localparam int FIFO_DEPTH = depth_of(FIFO_ADDR_W);

   // Lane geometry; the FSM threshold outputs are UMBRAL_W bits wide for every lane.
   localparam int MFS_DATA_W = FIFO_DATA_W;
   localparam int MFS_ADDR_W = FIFO_ADDR_W;
   localparam int VCS_DATA_W = FIFO_DATA_W;
   localparam int VCS_ADDR_W = FIFO_ADDR_W;
   localparam int D_DATA_W   = FIFO_DATA_W;
   localparam int D_ADDR_W   = FIFO_ADDR_W;
   localparam int UMBRAL_W   = FIFO_ADDR_W;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one registered read port.
// Only the read register is reset; the storage array is never cleared.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // A read of the slot being written in the same cycle returns the old word.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds and an overflow/underflow error.
// Define FIFO_STICKY_ERROR_EN to make error sticky until reset; otherwise it is a 1-cycle pulse.
module fifo_umbral
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   input  logic [ADDR_W-1:0] umbral_alto,
   input  logic [ADDR_W-1:0] umbral_bajo,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              error,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              valid_q, valid_d;
   logic              error_q, error_d;
   logic              wr_en, rd_en, overflow, underflow;

   // Push/pop protocol: no ready is returned. A push is taken when the FIFO is not full,
   // or when it is full but a pop retires a word in the same cycle. A pop is taken when
   // the FIFO is not empty and its word appears on data_out with valid_out one cycle later.
   // A refused push (overflow) or refused pop (underflow) is reported on error.
   always_comb begin
      wr_en     = push && (!full || pop);
      rd_en     = pop && !empty;
      overflow  = push && full && !pop;
      underflow = pop && empty;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = rd_en;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
`ifdef FIFO_STICKY_ERROR_EN
      error_d = error_q || overflow || underflow;
`else
      error_d = overflow || underflow;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out)
   );

   // Flags follow the live thresholds combinationally; a zero almost-full threshold disables it.
   always_comb begin
      empty        = (count_q == '0);
      full         = (count_q == DEPTH_CNT);
      almost_full  = (umbral_alto != '0) && (count_q >= {1'b0, umbral_alto});
      almost_empty = (count_q <= {1'b0, umbral_bajo});
   end

   assign valid_out = valid_q;
   assign error     = error_q;
   assign count     = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: a reference queue predicts read data into a scoreboard
// queue that a negedge monitor drains whenever valid_out is seen.
module tb_fifo_umbral;

   localparam int DATA_W = 6;
   localparam int ADDR_W = 3;
`ifdef FIFO_STICKY_ERROR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              push;
   logic [DATA_W-1:0] data_in;
   logic              pop;
   logic [ADDR_W-1:0] umbral_alto;
   logic [ADDR_W-1:0] umbral_bajo;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic              almost_empty;
   logic              error;
   logic [ADDR_W:0]   count;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mdl_q[$];
   bit                err_sticky = 1'b0;

   fifo_umbral dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .umbral_alto  (umbral_alto),
      .umbral_bajo  (umbral_bajo),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_flags(input string tag, input bit e_empty, input bit e_full,
                              input bit e_af, input bit e_ae);
      check({tag, " empty"}, int'(empty), int'(e_empty));
      check({tag, " full"}, int'(full), int'(e_full));
      check({tag, " almost_full"}, int'(almost_full), int'(e_af));
      check({tag, " almost_empty"}, int'(almost_empty), int'(e_ae));
   endtask

   // One clock of stimulus; the reference queue decides what is accepted.
   task automatic cycle(input logic p, input logic [DATA_W-1:0] d, input logic q);
      bit rd, e;
      int sz;
      sz = mdl_q.size();
      rd = q && (sz > 0);
      e  = (p && (sz == 8) && !q) || (q && (sz == 0));
      push = p; data_in = d; pop = q;
      if (rd) exp_q.push_back(mdl_q.pop_front());
      if (p && ((sz < 8) || q)) mdl_q.push_back(d);
      if (e) err_sticky = 1'b1;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0;
      check("count", int'(count), mdl_q.size());
      check("valid_out", int'(valid_out), int'(rd));
      check("error", int'(error), STICKY ? int'(err_sticky) : int'(e));
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (reset && valid_out) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL data_out: unexpected valid word %0h", data_out);
         end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            if (data_out != e) begin
               bad++;
               $display("FAIL data_out: got %0h expected %0h at %0t", data_out, e, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      total++;
      bad++;
      $display("FAIL watchdog: time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
      umbral_alto = 3'd6; umbral_bajo = 3'd1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("reset count", int'(count), 0);
      check("reset valid_out", int'(valid_out), 0);
      check("reset error", int'(error), 0);
      check("reset data_out", int'(data_out), 0);
      check_flags("reset", 1, 0, 0, 1);

      // Fill with 1..8, watching almost_full at 6 and full at 8.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, DATA_W'(i), 1'b0);
         check_flags("fill", 0, i == 8, i >= 6, i <= 1);
      end

      // Overflow: 0x3F must be dropped.
      cycle(1'b1, 6'h3F, 1'b0);
      check_flags("overflow", 0, 1, 1, 0);

      // Drain 1..8.
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, '0, 1'b1);
         check_flags("drain", k == 8, 0, (8 - k) >= 6, (8 - k) <= 1);
      end

      // Refill, then push+pop at full: oldest out, 0x2A travels round the pointers.
      for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(8'h10 + i), 1'b0);
      cycle(1'b1, 6'h2A, 1'b1);
      check_flags("full push+pop", 0, 1, 1, 0);
      for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1);

      // Underflow, then push+pop on empty.
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b1, 6'h05, 1'b1);
      check_flags("empty push+pop", 0, 0, 0, 1);
      cycle(1'b0, '0, 1'b1);

      // Live threshold changes.
      umbral_bajo = 3'd0; #1;
      check_flags("bajo0 empty", 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(8'h20 + i), 1'b0);
      check_flags("bajo0 cnt3", 0, 0, 0, 0);
      umbral_bajo = 3'd3; #1;
      check("almost_empty bajo3", int'(almost_empty), 1);
      umbral_bajo = 3'd2; #1;
      check("almost_empty bajo2", int'(almost_empty), 0);
      umbral_alto = 3'd3; #1;
      check("almost_full alto3", int'(almost_full), 1);
      umbral_alto = 3'd0; #1;
      check("almost_full disabled", int'(almost_full), 0);
      umbral_alto = 3'd4; #1;
      check("almost_full alto4", int'(almost_full), 0);
      cycle(1'b1, 6'h23, 1'b0);
      check("almost_full cnt4", int'(almost_full), 1);

      // Asynchronous reset between edges at count 4.
      @(negedge clk); #2;
      reset = 1'b0;
      mdl_q.delete();
      err_sticky = 1'b0;
      #1;
      check("async count", int'(count), 0);
      check("async empty", int'(empty), 1);
      check("async error", int'(error), 0);
      check("async valid_out", int'(valid_out), 0);
      @(negedge clk);
      reset = 1'b1;
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);

      @(negedge clk); #1;
      check("scoreboard drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
